// File: rtl/hyperbus_phase_pkg.sv
// Shared types and default constants for the HyperBus multi-phase clock generator.
package hyperbus_phase_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_DIV_WIDTH  = 8;

endpackage

// File: rtl/hyperbus_phase_gate.sv
// Per-phase output gate: suppresses partial pulses at start and lets a high pulse finish at stop.
module hyperbus_phase_gate (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic start_i,
    input  logic stop_i,
    input  logic raw_i,
    output logic phase_o,
    output logic frozen_o
);

    logic started_q, started_d;
    logic frozen_q, frozen_d;
    logic out_q, out_d;
    logic cand;

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        cand      = raw_i & (started_q | start_i) & ~frozen_q;
        started_d = started_q | start_i;
        frozen_d  = frozen_q;
        out_d     = cand;
        if (clr_i) begin
            started_d = 1'b0;
            frozen_d  = 1'b0;
            out_d     = 1'b0;
        end else if (stop_i) begin
            // Only a pulse already in flight may continue; it freezes on its natural fall.
            out_d    = out_q & cand;
            frozen_d = frozen_q | ~(out_q & cand);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            started_q <= 1'b0;
            frozen_q  <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            started_q <= started_d;
            frozen_q  <= frozen_d;
            out_q     <= out_d;
        end
    end

    assign phase_o  = out_q;
    assign frozen_o = frozen_q;

endmodule

// File: rtl/hyperbus_phase_gen.sv
// Generates NUM_PHASES equally spaced divided clocks with glitch-free start and stop.
module hyperbus_phase_gen
    import hyperbus_phase_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  cfg_div_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    output logic [NUM_PHASES-1:0] phase_o,
    output logic                  sync_o,
    output logic                  active_o
);

    localparam int CW = DIV_WIDTH + $clog2(NUM_PHASES);
    localparam int AW = CW + 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_wrap;
    logic [DIV_WIDTH-1:0]  step_q, step_d;
    logic                  sync_q, ready_q, active_q;
    logic [AW-1:0]         period_q, period_d, half_d, cnt_ext;
    logic [NUM_PHASES-1:0] frozen;

    assign period_q = AW'(step_q) * AW'(NUM_PHASES);
    assign period_d = AW'(step_d) * AW'(NUM_PHASES);
    assign half_d   = AW'(step_d) * AW'(NUM_PHASES / 2);
    assign cnt_ext  = {1'b0, cnt_d};

    always_comb begin
        cnt_wrap = cnt_q + CW'(1);
        if ({1'b0, cnt_q} + AW'(1) == period_q) cnt_wrap = '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_valid_i && ready_q)
                    step_d = (cfg_div_i == '0) ? DIV_WIDTH'(1) : cfg_div_i;
                if (en_i) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_wrap;
                if (!en_i) state_d = STOP;
            end
            STOP: begin
                if (&frozen) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_wrap;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate inputs are derived from next-state values so every output lands in a register.
    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
        logic [AW-1:0] off, diff;
        logic          raw, start;

        always_comb begin
            off = AW'(step_d) * AW'(k);
            if (cnt_ext >= off) diff = cnt_ext - off;
            else                diff = cnt_ext + period_d - off;
            raw   = diff < half_d;
            start = (state_d == RUN) && (cnt_ext == off);
        end

        hyperbus_phase_gate u_gate (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clr_i    (state_d == IDLE),
            .start_i  (start),
            .stop_i   (state_d == STOP),
            .raw_i    (raw),
            .phase_o  (phase_o[k]),
            .frozen_o (frozen[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= DIV_WIDTH'(1);
            sync_q   <= 1'b0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            sync_q   <= (state_d != IDLE) && (cnt_d == '0);
            ready_q  <= (state_d == IDLE);
            active_q <= (state_d != IDLE);
        end
    end

    assign cfg_ready_o = ready_q;
    assign sync_o      = sync_q;
    assign active_o    = active_q;

endmodule

// File: doc/hyperbus_phase_gen.md
HYPERBUS_PHASE_GEN -- requirements
Module: hyperbus_phase_gen

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, meaning the number of equally spaced phase outputs; it must be even and at least 2.
REQ-002 SHALL have parameter DIV_WIDTH, default 8, meaning the width of the step divider.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i, input, width 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, width 1: synchronous active-high reset.
REQ-006 SHALL have port en_i, input, width 1: run request, level-sensitive.
REQ-007 SHALL have port cfg_div_i, input, width DIV_WIDTH: requested step length in clk_i cycles.
REQ-008 SHALL have port cfg_valid_i, input, width 1: cfg_div_i is valid.
REQ-009 SHALL have port cfg_ready_o, output, width 1: the config is accepted on cfg_valid_i & cfg_ready_o.
REQ-010 SHALL have port phase_o, output, width NUM_PHASES: bit k is the divided clock shifted by k*360/NUM_PHASES degrees.
REQ-011 SHALL have port sync_o, output, width 1: one-cycle pulse at the start of each output period.
REQ-012 SHALL have port active_o, output, width 1: high when not IDLE.

Function
REQ-013 SHALL hold a step register step_q; on a config handshake step_q = cfg_div_i, and a value of 0 SHALL be stored as 1.
REQ-014 SHALL have output period P = NUM_PHASES*step_q; the counter cnt is DIV_WIDTH+$clog2(NUM_PHASES) bits wide, counts 0..P-1 and wraps to 0.
REQ-015 SHALL define the raw phase k as high when ((cnt - k*step_q) mod P) < P/2; the subtraction is computed without overflow: cnt-k*step_q if cnt>=k*step_q, else cnt+P-k*step_q.
REQ-016 SHALL have states IDLE, RUN, STOP; every output is registered, with no combinational input-to-output path.
REQ-017 IDLE: cnt=0, phase_o=0, sync_o=0, cfg_ready_o=1; if en_i=1, the next cycle enters RUN with cnt=0, sync_o=1 and phase_o[0]=1.
REQ-018 RUN start gating: each phase k stays low until its first raw rising edge, at cnt=k*step_q; raw-high-at-start phases (k>NUM_PHASES/2) produce no partial pulse.
REQ-019 RUN: phase_o follows the gated raw phases; sync_o=1 exactly in cycles with cnt=0; cfg_ready_o=0.
REQ-020 RUN with en_i=0 sampled: enter STOP; the counter keeps running; a phase that is low at that point is frozen low immediately; a high phase completes its pulse and is frozen low at its natural falling edge.
REQ-021 STOP: cfg_ready_o=0; sync_o continues at cnt=0; en_i is ignored.
REQ-022 STOP exit: once all phases are frozen, the next cycle is IDLE with cnt=0; if en_i=1 then, RUN restarts per REQ-017.
REQ-023 SHALL never emit a phase_o high or low pulse shorter than P/2 cycles except the final low (frozen) level.
REQ-024 A cfg_valid_i outside IDLE SHALL be ignored, with no queuing; step_q stays unchanged during RUN and STOP.
REQ-025 If a config handshake and en_i=1 occur in the same IDLE cycle, the new step_q SHALL apply to the starting RUN.

Reset
REQ-026 rst_i SHALL force, in the same edge and overriding every other input: state=IDLE, cnt=0, step_q=1, phase_o=0, sync_o=0, active_o=0, cfg_ready_o=1, and all gating flags cleared.
REQ-027 Reset mid-RUN or mid-STOP SHALL drop all phases low immediately; truncated pulses are accepted only here.

Structure
REQ-028 Package hyperbus_phase_pkg SHALL hold the state enum (IDLE/RUN/STOP) and the default parameter constants.
REQ-029 Sub-module hyperbus_phase_gate (one per phase, generate loop) SHALL hold the started/frozen flags and the output register, driven by raw phase, start and stop controls.

Verification
REQ-030 Scenario: NUM_PHASES=4, step 1, en_i=1 -> period 4; phase_o[0..3] rise at cnt 0,1,2,3; sync_o every 4 cycles; phase_o[3] first high at cnt 3.
REQ-031 Scenario: cfg_div_i=3 accepted in IDLE, then run -> P=12; phase k rises at cnt 3k, high 6 cycles; cfg_valid_i with 5 during RUN -> cfg_ready_o=0 and step_q stays 3.
REQ-032 Scenario: step 2, en_i dropped at cnt=5 -> every phase high pulse is 4 cycles, each phase frozen low at its falling edge; IDLE is reached, then active_o=0 next cycle.
REQ-033 Scenario: cfg_div_i=0 accepted -> behaves as step 1 (P=4).
REQ-034 Scenario: rst_i asserted at cnt=2 in RUN -> next cycle phase_o=0, state IDLE, step_q=1.
REQ-035 Scenario: en_i re-asserted during STOP -> ignored until IDLE; the restart begins the cycle after IDLE with cnt=0 and phase_o[0]=1.
